dir_cmd_queue: RTL and testbench

- Buffers player direction commands between the input sources and the movement engine.
- Inputs are the OR-merged direction sources: push buttons, PS/2 key_down bits and online lines.
- Each new press becomes a queued command; illegal and redundant turns are filtered out.
- One command is released per movement tick, so rapid double-turns (e.g. up then left inside one step) are not lost and cannot produce a 180-degree reversal.

---
 rtl/dir_cmd_queue_if.sv | 26 ++
 rtl/dir_cmd_queue.sv | 87 ++++++++
 tb/tb_dir_cmd_queue.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/dir_cmd_queue_if.sv
// rtl/dir_cmd_queue_if.sv - direction command queue signal bundle
interface dir_cmd_queue_if #(
  parameter int CW = 3
);
  logic          clear;
  logic          up;
  logic          down;
  logic          left;
  logic          right;
  logic          move_tick;
  logic [1:0]    dir_out;
  logic          dir_changed;
  logic [CW-1:0] count;
  logic          full;
  logic          overflow;

  modport master (
    output clear, up, down, left, right, move_tick,
    input  dir_out, dir_changed, count, full, overflow
  );

  modport slave (
    input  clear, up, down, left, right, move_tick,
    output dir_out, dir_changed, count, full, overflow
  );
endinterface

// File: rtl/dir_cmd_queue.sv
// rtl/dir_cmd_queue.sv - edge-detected, turn-filtered direction FIFO released per move tick
module dir_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  dir_cmd_queue_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]    mem_q [DEPTH];
  logic [3:0]    in_d, in_q, rise;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q, tail_ptr;
  logic [CW-1:0] count_q;
  logic [1:0]    dir_q;
  logic          changed_q;
  logic          ovf_q;

  logic [1:0]    cand;
  logic          cand_vld;
  logic [1:0]    ref_dir;
  logic          legal, is_full, pop, push, drop;

  assign in_d = {bus.up, bus.down, bus.left, bus.right};
  assign rise = in_d & ~in_q;

  always_comb begin
    cand     = 2'd0;
    cand_vld = |rise;
    if (rise[3])      cand = 2'd2;
    else if (rise[2]) cand = 2'd3;
    else if (rise[1]) cand = 2'd1;
    else              cand = 2'd0;
  end

  // Same and opposite directions share bit 1 (right/left = 0x, up/down = 1x),
  // so a turn is legal exactly when that bit differs from the reference.
  assign tail_ptr = wr_ptr_q - PW'(1);
  assign ref_dir  = (count_q != '0) ? mem_q[tail_ptr] : dir_q;
  assign legal    = cand_vld && (cand[1] != ref_dir[1]);
  assign is_full  = (count_q == CW'(DEPTH));
  assign pop      = bus.move_tick && (count_q != '0);
  assign push     = legal && (!is_full || pop) && !bus.clear;
  assign drop     = legal && is_full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cand;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q      <= 4'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dir_q     <= 2'd0;
      changed_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      in_q <= in_d;
      if (bus.clear) begin
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        count_q   <= '0;
        dir_q     <= 2'd0;
        changed_q <= 1'b0;
        ovf_q     <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
          dir_q    <= mem_q[rd_ptr_q];
        end
        changed_q <= pop;
        count_q   <= count_q + CW'(push) - CW'(pop);
        if (drop) ovf_q <= 1'b1;
      end
    end
  end

  assign bus.dir_out     = dir_q;
  assign bus.dir_changed = changed_q;
  assign bus.count       = count_q;
  assign bus.full        = is_full;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_dir_cmd_queue.sv
// tb/tb_dir_cmd_queue.sv - scoreboard bench for dir_cmd_queue
module tb_dir_cmd_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic done = 1'b0;
  int   checks = 0;
  int   failures = 0;

  dir_cmd_queue_if #(.CW(3)) bus_if ();

  dir_cmd_queue #(.DEPTH(4), .CW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Scoreboard queues: expected dir on each dir_changed pulse, and status snapshots.
  int    dq[$];
  string st_nm[$];
  int    st_cnt[$];
  int    st_full[$];
  int    st_ovf[$];
  int    st_dir[$];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string nm, input int c, input int f, input int o, input int d);
    st_nm.push_back(nm);
    st_cnt.push_back(c);
    st_full.push_back(f);
    st_ovf.push_back(o);
    st_dir.push_back(d);
  endtask

  // 0=right 1=left 2=up 3=down
  task automatic pulse_dir(input int d);
    case (d)
      0: bus_if.right = 1'b1;
      1: bus_if.left  = 1'b1;
      2: bus_if.up    = 1'b1;
      default: bus_if.down = 1'b1;
    endcase
    step(1);
    bus_if.up = 1'b0; bus_if.down = 1'b0; bus_if.left = 1'b0; bus_if.right = 1'b0;
    step(1);
  endtask

  task automatic tick(input int exp_dir);
    if (exp_dir >= 0) dq.push_back(exp_dir);
    bus_if.move_tick = 1'b1;
    step(1);
    bus_if.move_tick = 1'b0;
  endtask

  task automatic do_clear();
    bus_if.clear = 1'b1;
    step(1);
    bus_if.clear = 1'b0;
    step(1);
  endtask

  task automatic fill4();
    pulse_dir(2); pulse_dir(1); pulse_dir(3); pulse_dir(0);
  endtask

  always @(negedge clk) begin
    while (st_nm.size() > 0) begin
      string nm;
      int c, f, o, d;
      nm = st_nm.pop_front();
      c = st_cnt.pop_front(); f = st_full.pop_front();
      o = st_ovf.pop_front(); d = st_dir.pop_front();
      checks += 4;
      if (int'(bus_if.count) != c) begin
        failures++; $display("FAIL %s count actual=%0d expected=%0d", nm, bus_if.count, c);
      end
      if (int'(bus_if.full) != f) begin
        failures++; $display("FAIL %s full actual=%0d expected=%0d", nm, bus_if.full, f);
      end
      if (int'(bus_if.overflow) != o) begin
        failures++; $display("FAIL %s overflow actual=%0d expected=%0d", nm, bus_if.overflow, o);
      end
      if (int'(bus_if.dir_out) != d) begin
        failures++; $display("FAIL %s dir_out actual=%0d expected=%0d", nm, bus_if.dir_out, d);
      end
    end
    if (bus_if.dir_changed) begin
      checks++;
      if (dq.size() == 0) begin
        failures++;
        $display("FAIL dir_changed unexpected pulse dir_out=%0d expected no pulse", bus_if.dir_out);
      end else begin
        int e;
        e = dq.pop_front();
        if (int'(bus_if.dir_out) != e) begin
          failures++; $display("FAIL applied_dir actual=%0d expected=%0d", bus_if.dir_out, e);
        end
      end
    end
    if (done) begin
      checks++;
      if (dq.size() != 0) begin
        failures++; $display("FAIL missing_dir_changed pending=%0d expected=0", dq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus_if.clear = 1'b0; bus_if.move_tick = 1'b0;
    bus_if.up = 1'b0; bus_if.down = 1'b0; bus_if.left = 1'b0; bus_if.right = 1'b0;
    step(2);
    expect_st("reset", 0, 0, 0, 0);
    step(1);
    rst_n = 1'b1;
    step(1);

    // 1: ticks on an empty queue
    tick(-1); step(2); tick(-1); step(2); tick(-1); step(2);
    expect_st("idle_ticks", 0, 0, 0, 0);

    // 2: up then left, released one per tick
    pulse_dir(2);
    step(3);
    pulse_dir(1);
    expect_st("two_queued", 2, 0, 0, 0);
    step(10);
    tick(2);
    expect_st("after_tick1", 1, 0, 0, 2);
    step(20);
    tick(1);
    expect_st("after_tick2", 0, 0, 0, 1);
    step(2);

    // 3: filtering against dir_out and newest entry
    do_clear();
    expect_st("clear_dir", 0, 0, 0, 0);
    pulse_dir(1);
    pulse_dir(0);
    expect_st("reject_opp_same", 0, 0, 0, 0);
    pulse_dir(2);
    pulse_dir(3);
    expect_st("reject_vs_tail", 1, 0, 0, 0);
    tick(2);
    expect_st("filter_drain", 0, 0, 0, 2);
    step(2);

    // 4: full queue, overflow, then same press with a pop
    do_clear();
    fill4();
    expect_st("full4", 4, 1, 0, 0);
    pulse_dir(2);
    expect_st("overflow", 4, 1, 1, 0);
    do_clear();
    expect_st("clear_ovf", 0, 0, 0, 0);
    fill4();
    bus_if.up = 1'b1;
    tick(2);
    bus_if.up = 1'b0;
    step(1);
    expect_st("push_pop_full", 4, 1, 0, 2);
    tick(1); step(1);
    tick(3); step(1);
    tick(0); step(1);
    tick(2); step(1);
    expect_st("drain4", 0, 0, 0, 2);
    step(2);

    // 5: simultaneous rises and a held level
    do_clear();
    bus_if.up = 1'b1; bus_if.right = 1'b1;
    step(1);
    bus_if.right = 1'b0;
    expect_st("priority_up", 1, 0, 0, 0);
    step(100);
    expect_st("held_no_repeat", 1, 0, 0, 0);
    bus_if.up = 1'b0;
    tick(2);
    expect_st("priority_drain", 0, 0, 0, 2);
    step(2);

    // 6a: clear with overflow and entries pending
    do_clear();
    fill4();
    pulse_dir(2);
    tick(2);
    expect_st("pre_clear", 3, 0, 1, 2);
    step(1);
    do_clear();
    expect_st("post_clear", 0, 0, 0, 0);
    tick(-1); step(2);
    expect_st("clear_tick", 0, 0, 0, 0);

    // 6b: asynchronous reset mid-operation
    fill4();
    pulse_dir(2);
    tick(2);
    expect_st("pre_reset", 3, 0, 1, 2);
    step(1);
    #2 rst_n = 1'b0;
    #1 expect_st("in_reset", 0, 0, 0, 0);
    step(1);
    rst_n = 1'b1;
    step(1);
    tick(-1); step(2);
    expect_st("reset_tick", 0, 0, 0, 0);

    step(3);
    done = 1'b1;
  end
endmodule
